// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  // Function codes that get special treatment before the ALU is engaged
  localparam logic [3:0] FUNC_DIV     = 4'b0011;
  localparam logic [3:0] FUNC_INVALID = 4'b1111;

  // Requester identifier width (two requesters)
  localparam int REQ_ID_W = 1;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester and ALU side signals of the arbiter, bundled as one bus.
interface alu_arbiter_if #(
  parameter int DATA_WIDTH = 8
);

  logic [1:0]              req_valid;
  logic [1:0]              req_ready;
  logic [DATA_WIDTH-1:0]   req0_A;
  logic [DATA_WIDTH-1:0]   req0_B;
  logic [3:0]              req0_func;
  logic [DATA_WIDTH-1:0]   req1_A;
  logic [DATA_WIDTH-1:0]   req1_B;
  logic [3:0]              req1_func;
  logic [DATA_WIDTH-1:0]   alu_A;
  logic [DATA_WIDTH-1:0]   alu_B;
  logic [3:0]              alu_function;
  logic                    alu_enable;
  logic                    alu_result_valid;
  logic [2*DATA_WIDTH-1:0] alu_result;
  logic [1:0]              resp_valid;
  logic [2*DATA_WIDTH-1:0] resp_result;
  logic                    resp_error;

  // Arbiter side
  modport slave (
    input  req_valid, req0_A, req0_B, req0_func, req1_A, req1_B, req1_func,
    input  alu_result_valid, alu_result,
    output req_ready, alu_A, alu_B, alu_function, alu_enable,
    output resp_valid, resp_result, resp_error
  );

  // Requesters plus ALU side
  modport master (
    output req_valid, req0_A, req0_B, req0_func, req1_A, req1_B, req1_func,
    output alu_result_valid, alu_result,
    input  req_ready, alu_A, alu_B, alu_function, alu_enable,
    input  resp_valid, resp_result, resp_error
  );

endinterface

// File: rtl/alu_arbiter_rr_arbiter2.sv
// Two-input round-robin grant: under contention the requester that did not
// win last time is granted; a lone requester always wins.
module rr_arbiter2 (
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // One-hot grant selection
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters: round-robin acceptance, illegal-op
// screening, ALU sequencing and per-requester response pulses.
module alu_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  alu_arbiter_if.slave  bus
);

  state_t                  state;
  logic [REQ_ID_W-1:0]     last_grant;
  logic [REQ_ID_W-1:0]     req_id;
  logic [1:0]              grant;
  logic [1:0]              req_ready_c;
  logic                    handshake;
  logic [REQ_ID_W-1:0]     sel_id;
  logic [DATA_WIDTH-1:0]   sel_a;
  logic [DATA_WIDTH-1:0]   sel_b;
  logic [3:0]              sel_func;

  logic [DATA_WIDTH-1:0]   alu_a_r;
  logic [DATA_WIDTH-1:0]   alu_b_r;
  logic [3:0]              alu_func_r;
  logic                    alu_en_r;
  logic [1:0]              resp_valid_r;
  logic [2*DATA_WIDTH-1:0] resp_result_r;
  logic                    resp_error_r;

  // Operations the ALU must never see
  function automatic logic is_illegal(input logic [3:0] func,
                                      input logic [DATA_WIDTH-1:0] b);
    return (func == FUNC_INVALID) || ((func == FUNC_DIV) && (b == '0));
  endfunction

  function automatic logic [1:0] id_onehot(input logic [REQ_ID_W-1:0] id);
    return (id != '0) ? 2'b10 : 2'b01;
  endfunction

  rr_arbiter2 u_rr_arbiter2 (
    .req_valid  (bus.req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Ready only offered while idle; operand mux follows the winner
  always_comb begin
    req_ready_c = 2'b00;
    if ((state == IDLE) && !reset) begin
      req_ready_c = grant;
    end
    handshake = |(bus.req_valid & req_ready_c);
    sel_id    = grant[1];
    sel_a     = grant[1] ? bus.req1_A    : bus.req0_A;
    sel_b     = grant[1] ? bus.req1_B    : bus.req0_B;
    sel_func  = grant[1] ? bus.req1_func : bus.req0_func;
  end

  // Control FSM with registered ALU and response outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      req_id        <= '0;
      alu_a_r       <= '0;
      alu_b_r       <= '0;
      alu_func_r    <= '0;
      alu_en_r      <= 1'b0;
      resp_valid_r  <= 2'b00;
      resp_result_r <= '0;
      resp_error_r  <= 1'b0;
    end else begin
      alu_en_r     <= 1'b0;
      resp_valid_r <= 2'b00;
      case (state)
        IDLE: begin
          if (handshake) begin
            last_grant <= sel_id;
            req_id     <= sel_id;
            if (is_illegal(sel_func, sel_b)) begin
              resp_result_r <= '0;
              resp_error_r  <= 1'b1;
              resp_valid_r  <= id_onehot(sel_id);
              state         <= RESP;
            end else begin
              alu_a_r    <= sel_a;
              alu_b_r    <= sel_b;
              alu_func_r <= sel_func;
              alu_en_r   <= 1'b1;
              state      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          resp_result_r <= bus.alu_result_valid ? bus.alu_result : '0;
          resp_error_r  <= ~bus.alu_result_valid;
          resp_valid_r  <= id_onehot(req_id);
          state         <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready    = req_ready_c;
  assign bus.alu_A        = alu_a_r;
  assign bus.alu_B        = alu_b_r;
  assign bus.alu_function = alu_func_r;
  assign bus.alu_enable   = alu_en_r;
  assign bus.resp_valid   = resp_valid_r;
  assign bus.resp_result  = resp_result_r;
  assign bus.resp_error   = resp_error_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural single-cycle ALU.
module tb_alu_arbiter;

  localparam logic [3:0] F_ADD = 4'h0;
  localparam logic [3:0] F_SUB = 4'h1;
  localparam logic [3:0] F_MUL = 4'h2;
  localparam logic [3:0] F_DIV = 4'h3;
  localparam logic [3:0] F_AND = 4'h4;
  localparam logic [3:0] F_BAD = 4'hF;

  logic clk;
  logic reset;
  logic force_invalid;
  int   n_checks;
  int   n_errors;
  int   en_count;
  int   en_snap;

  alu_arbiter_if #(.DATA_WIDTH(8)) bus ();

  alu_arbiter #(.DATA_WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] alu_model(input logic [3:0] f,
                                            input logic [7:0] a,
                                            input logic [7:0] b);
    logic [15:0] a16;
    logic [15:0] b16;
    a16 = {8'h00, a};
    b16 = {8'h00, b};
    case (f)
      F_ADD:   return a16 + b16;
      F_SUB:   return a16 - b16;
      F_MUL:   return a16 * b16;
      F_DIV:   return (b16 != 16'h0) ? a16 / b16 : 16'h0;
      F_AND:   return a16 & b16;
      default: return 16'h0;
    endcase
  endfunction

  // Behavioural ALU: output registered one cycle after enable
  always @(posedge clk) begin
    bus.alu_result_valid <= 1'b0;
    if (bus.alu_enable) begin
      bus.alu_result_valid <= !force_invalid;
      bus.alu_result       <= alu_model(bus.alu_function, bus.alu_A, bus.alu_B);
    end
  end

  always @(posedge clk) begin
    if (bus.alu_enable) en_count <= en_count + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [3:0] f,
                         input logic [7:0] a, input logic [7:0] b);
    if (id == 0) begin
      bus.req0_func = f; bus.req0_A = a; bus.req0_B = b;
    end else begin
      bus.req1_func = f; bus.req1_A = a; bus.req1_B = b;
    end
  endtask

  // Called at the negedge of an idle cycle with the request already driven;
  // returns at the negedge of the response cycle.
  task automatic legal_seq(input string tag, input logic [1:0] exp_ready,
                           input logic [7:0] ea, input logic [7:0] eb,
                           input logic [3:0] ef, input logic [1:0] valid_after,
                           input logic [15:0] eres, input logic eerr);
    #1;
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'(exp_ready));
    @(negedge clk);
    bus.req_valid = valid_after;
    chk({tag, "_en1"},    32'(bus.alu_enable),   32'd1);
    chk({tag, "_aluA"},   32'(bus.alu_A),        32'(ea));
    chk({tag, "_aluB"},   32'(bus.alu_B),        32'(eb));
    chk({tag, "_func"},   32'(bus.alu_function), 32'(ef));
    chk({tag, "_rdy0"},   32'(bus.req_ready),    32'd0);
    @(negedge clk);
    chk({tag, "_en0"},    32'(bus.alu_enable),   32'd0);
    chk({tag, "_noresp"}, 32'(bus.resp_valid),   32'd0);
    @(negedge clk);
    chk({tag, "_rvalid"}, 32'(bus.resp_valid),   32'(exp_ready));
    chk({tag, "_result"}, 32'(bus.resp_result),  32'(eres));
    chk({tag, "_error"},  32'(bus.resp_error),   32'(eerr));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    en_count = 0;
    force_invalid = 1'b0;
    reset = 1'b1;
    bus.req_valid = 2'b00;
    set_req(0, F_ADD, 8'h00, 8'h00);
    set_req(1, F_ADD, 8'h00, 8'h00);

    // Reset values, with requests pending during reset
    repeat (3) @(negedge clk);
    bus.req_valid = 2'b11;
    #1;
    chk("rst_ready",  32'(bus.req_ready),    32'd0);
    chk("rst_en",     32'(bus.alu_enable),   32'd0);
    chk("rst_aluA",   32'(bus.alu_A),        32'd0);
    chk("rst_func",   32'(bus.alu_function), 32'd0);
    chk("rst_rvalid", 32'(bus.resp_valid),   32'd0);
    chk("rst_result", 32'(bus.resp_result),  32'd0);
    chk("rst_error",  32'(bus.resp_error),   32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.req_valid = 2'b00;

    // req0 alone: 5 + 3
    @(negedge clk);
    set_req(0, F_ADD, 8'h05, 8'h03);
    bus.req_valid = 2'b01;
    legal_seq("add", 2'b01, 8'h05, 8'h03, F_ADD, 2'b00, 16'h0008, 1'b0);
    @(negedge clk);
    chk("add_pulse", 32'(bus.resp_valid), 32'd0);

    // Fresh reset, then contention held across three operations
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    set_req(0, F_MUL, 8'hFF, 8'hFF);
    set_req(1, F_SUB, 8'h10, 8'h01);
    bus.req_valid = 2'b11;
    legal_seq("c0", 2'b01, 8'hFF, 8'hFF, F_MUL, 2'b11, 16'hFE01, 1'b0);
    @(negedge clk);
    legal_seq("c1", 2'b10, 8'h10, 8'h01, F_SUB, 2'b11, 16'h000F, 1'b0);
    @(negedge clk);
    legal_seq("c2", 2'b01, 8'hFF, 8'hFF, F_MUL, 2'b00, 16'hFE01, 1'b0);

    // req1 divide by zero: rejected, ALU untouched
    @(negedge clk);
    en_snap = en_count;
    set_req(1, F_DIV, 8'h20, 8'h00);
    bus.req_valid = 2'b10;
    #1;
    chk("div0_ready", 32'(bus.req_ready), 32'd2);
    @(negedge clk);
    bus.req_valid = 2'b00;
    chk("div0_rvalid", 32'(bus.resp_valid),  32'd2);
    chk("div0_error",  32'(bus.resp_error),  32'd1);
    chk("div0_result", 32'(bus.resp_result), 32'd0);
    chk("div0_en",     32'(bus.alu_enable),  32'd0);
    @(negedge clk);
    chk("div0_pulse",  32'(bus.resp_valid),  32'd0);
    chk("div0_noalu",  32'(en_count),        32'(en_snap));

    // req0 invalid function, then an immediate legal AND
    set_req(0, F_BAD, 8'h12, 8'h34);
    bus.req_valid = 2'b01;
    #1;
    chk("bad_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    chk("bad_rvalid", 32'(bus.resp_valid),  32'd1);
    chk("bad_error",  32'(bus.resp_error),  32'd1);
    chk("bad_result", 32'(bus.resp_result), 32'd0);
    chk("bad_noalu",  32'(en_count),        32'(en_snap));
    set_req(0, F_AND, 8'hF0, 8'h3C);
    @(negedge clk);
    legal_seq("and", 2'b01, 8'hF0, 8'h3C, F_AND, 2'b00, 16'h0030, 1'b0);

    // Reset during CAPTURE of a req1 operation
    @(negedge clk);
    set_req(1, F_ADD, 8'h11, 8'h22);
    bus.req_valid = 2'b10;
    #1;
    chk("r1_ready", 32'(bus.req_ready), 32'd2);
    @(negedge clk);
    bus.req_valid = 2'b00;
    chk("r1_en", 32'(bus.alu_enable), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("r1_rvalid", 32'(bus.resp_valid),   32'd0);
    chk("r1_en0",    32'(bus.alu_enable),   32'd0);
    chk("r1_aluA",   32'(bus.alu_A),        32'd0);
    chk("r1_aluB",   32'(bus.alu_B),        32'd0);
    chk("r1_func",   32'(bus.alu_function), 32'd0);
    chk("r1_result", 32'(bus.resp_result),  32'd0);
    chk("r1_error",  32'(bus.resp_error),   32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("r1_noresp", 32'(bus.resp_valid), 32'd0);
    set_req(0, F_ADD, 8'h01, 8'h01);
    set_req(1, F_ADD, 8'h02, 8'h02);
    bus.req_valid = 2'b11;
    legal_seq("r1c", 2'b01, 8'h01, 8'h01, F_ADD, 2'b00, 16'h0002, 1'b0);

    // Reset during ISSUE of a req0 operation: grant pointer must return
    @(negedge clk);
    set_req(0, F_ADD, 8'h07, 8'h08);
    bus.req_valid = 2'b01;
    #1;
    chk("r0_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    chk("r0_en", 32'(bus.alu_enable), 32'd1);
    reset = 1'b1;
    bus.req_valid = 2'b00;
    @(negedge clk);
    chk("r0_en0",    32'(bus.alu_enable), 32'd0);
    chk("r0_rvalid", 32'(bus.resp_valid), 32'd0);
    reset = 1'b0;
    set_req(0, F_ADD, 8'h01, 8'h01);
    set_req(1, F_ADD, 8'h02, 8'h02);
    bus.req_valid = 2'b11;
    legal_seq("r0c", 2'b01, 8'h01, 8'h01, F_ADD, 2'b00, 16'h0002, 1'b0);

    // ALU reports invalid result, then normal operation resumes
    @(negedge clk);
    force_invalid = 1'b1;
    set_req(0, F_SUB, 8'h30, 8'h10);
    bus.req_valid = 2'b01;
    legal_seq("inv", 2'b01, 8'h30, 8'h10, F_SUB, 2'b00, 16'h0000, 1'b1);
    force_invalid = 1'b0;
    @(negedge clk);
    set_req(1, F_ADD, 8'h01, 8'h02);
    bus.req_valid = 2'b10;
    legal_seq("resume", 2'b10, 8'h01, 8'h02, F_ADD, 2'b00, 16'h0003, 1'b0);
    @(negedge clk);
    chk("resume_pulse", 32'(bus.resp_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

- Shares one ALU instance between two requesters.
- Each requester posts an operation through a valid/ready handshake.
- A round-robin arbiter accepts one operation at a time and sequences the ALU (operands, function code, enable).
- The result is returned to the originating requester; illegal operations are rejected before reaching the ALU.

## Interface
Parameters:
- DATA_WIDTH, 8, operand width; result width is 2*DATA_WIDTH

Ports:
- clk  in  1  system clock
- reset  in  1  Reset is synchronous and active-high; there is one clock.
- req_valid  in  2  per-requester operation valid (bit n = requester n)
- req_ready  out  2  per-requester accept; at most one bit high
- req0_A, req0_B  in  DATA_WIDTH each  requester 0 operands
- req0_func  in  4  requester 0 ALU function code
- req1_A, req1_B  in  DATA_WIDTH each  requester 1 operands
- req1_func  in  4  requester 1 ALU function code
- alu_A, alu_B  out  DATA_WIDTH each  operands to ALU (registered)
- alu_function  out  4  function code to ALU (registered)
- alu_enable  out  1  ALU enable, single-cycle pulse
- alu_result_valid  in  1  ALU output valid (ALU registers its output one cycle after enable)
- alu_result  in  2*DATA_WIDTH  ALU result
- resp_valid  out  2  one-hot response pulse to requester n
- resp_result  out  2*DATA_WIDTH  result for the responding requester
- resp_error  out  1  qualifies resp_valid: operation rejected or ALU returned invalid

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - req_ready is driven combinationally to the arbitration winner among set req_valid bits.
  - A handshake (valid & ready) latches operands, function and requester ID.
  - Legal op → ISSUE.
  - Illegal op → RESP with error set; the ALU is never enabled.
- Illegal ops:
  - func = 4'b1111.
  - func = 4'b0011 (divide) with B = 0.
- ISSUE: alu_enable = 1 for exactly one cycle; alu_A/alu_B/alu_function hold the latched values. → CAPTURE.
- CAPTURE:
  - Registers alu_result into resp_result.
  - resp_error = ~alu_result_valid.
  - → RESP.
- RESP:
  - resp_valid[id] = 1 for one cycle, with resp_result/resp_error stable.
  - No backpressure; requesters must accept.
  - → IDLE.
- Arbitration:
  - Round-robin via a last_grant register, updated on each handshake.
  - If both valid, grant the requester ≠ last_grant.
  - If one valid, grant it regardless of last_grant.
  - last_grant resets to 1, so requester 0 wins the first contention.
- req_ready is 0 in every state except IDLE.
- A requester must hold req_valid and its fields stable until its ready is seen.
- Error responses drive resp_result = 0.

## Timing
- Reset values: state IDLE, last_grant = 1, req_ready = 0, alu_A/alu_B/alu_function = 0, alu_enable = 0, resp_valid = 0, resp_result = 0, resp_error = 0.
- Legal op, handshake at edge T:
  - alu_enable high during cycle T+1.
  - alu_result_valid/alu_result valid during T+2, captured at the T+2 edge.
  - resp_valid high during T+3.
- Illegal op, handshake at T: resp_valid high during T+1.
- Throughput: legal op every 4 cycles, error op every 2 cycles. The next handshake may occur in the cycle after RESP, at the earliest.
- Requests arriving in ISSUE/CAPTURE/RESP wait; they are never dropped.
- Reset asserted mid-operation:
  - The in-flight operation is discarded; no resp_valid is produced.
  - alu_enable is 0 the next cycle.
  - last_grant returns to 1.
- Results are passed through at full 2*DATA_WIDTH; no truncation or sign extension.

## Structure
- Shared package alu_ctrl_pkg holds:
  - state enum (IDLE, ISSUE, CAPTURE, RESP);
  - function constants FUNC_DIV = 4'b0011, FUNC_INVALID = 4'b1111;
  - REQ_ID width constant.
- One sub-module, rr_arbiter2: 2-input round-robin grant from req_valid and last_grant.
- The FSM, operand/result registers and illegal-op check stay in alu_arbiter.

## Test plan
- Reset, then req0 only: add A=8'h05, B=8'h03 → req_ready=2'b01 at T, alu_enable at T+1, resp_valid=2'b01 with resp_result=16'h0008 and resp_error=0 at T+3.
- Both requesters valid, held for three ops:
  - req0 multiply 8'hFF×8'hFF, req1 subtract 8'h10−8'h01.
  - Grant order req0, req1, req0; results 16'hFE01, 16'h000F.
- req1 divide with B=0 → resp_valid=2'b10 one cycle after handshake; resp_error=1, resp_result=0; alu_enable never asserted.
- req0 func=4'b1111 → error response at T+1; then an immediate req0 AND 8'hF0&8'h3C accepted the following cycle, returning 16'h0030.
- Reset pulsed during CAPTURE of a req1 op → no resp_valid; all outputs at reset values; next contention grants req0 first.
- Model ALU returning alu_result_valid=0 in CAPTURE → resp_error=1 to the issuing requester; arbiter resumes normally.
